// File: rtl/bus_arbiter4x16_pkg.sv
// bus_arbiter4x16_pkg: shared state encodings and constants for the bus arbiter
package bus_arbiter4x16_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;
    localparam int N_REQ = 4;
    localparam logic [1:0] LAST_RST = 2'd3;
endpackage

// File: rtl/gmux4way16.sv
// gmux4way16: 4-way WIDTH-bit multiplexer
module gmux4way16 #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic [WIDTH-1:0] d,
    input  logic [1:0]       sel,
    output logic [WIDTH-1:0] out
);
    always_comb out = sel[1] ? (sel[0] ? d : c) : (sel[0] ? b : a);
endmodule

// File: rtl/bus_arbiter4x16.sv
// bus_arbiter4x16: round-robin arbiter snapshotting the winner's word under valid/ready
module bus_arbiter4x16
    import bus_arbiter4x16_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] din0,
    input  logic [WIDTH-1:0] din1,
    input  logic [WIDTH-1:0] din2,
    input  logic [WIDTH-1:0] din3,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       sel,
    output logic [3:0]       grant
);
    state_t           state;
    logic [1:0]       last;
    logic [1:0]       win;
    logic [WIDTH-1:0] mux_out;

    // Scan downward so the lowest offset from last+1 is assigned last and wins
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
        logic [1:0] w;
        w = l;
        for (int i = N_REQ; i >= 1; i--)
            if (r[2'(l + 2'(i))]) w = 2'(l + 2'(i));
        return w;
    endfunction

    always_comb win = rr_pick(req, last);

    gmux4way16 #(.WIDTH(WIDTH)) u_mux (
        .a(din0), .b(din1), .c(din2), .d(din3), .sel(win), .out(mux_out)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            last      <= LAST_RST;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel       <= 2'd0;
            grant     <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: if (|req) begin
                    sel       <= win;
                    out_data  <= mux_out;
                    out_valid <= 1'b1;
                    state     <= ST_BUSY;
                end
                ST_BUSY: if (out_valid && out_ready) begin
                    out_valid <= 1'b0;
                    last      <= sel;
                    grant     <= 4'd1 << sel;
                    state     <= ST_DONE;
                end
                default: begin
                    grant <= 4'd0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bus_arbiter4x16.sv
// tb_bus_arbiter4x16: table-driven directed check of the round-robin bus arbiter
module tb_bus_arbiter4x16;
    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [15:0] d0, d1, d2, d3;
        logic        rdy;
        logic        ev;
        logic [15:0] ed;
        logic [1:0]  es;
        logic [3:0]  eg;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] din0, din1, din2, din3;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [1:0]  sel;
    logic [3:0]  grant;

    int checks = 0;
    int errors = 0;
    vec_t vq[$];

    bus_arbiter4x16 #(.WIDTH(16)) dut (
        .clk(clk), .reset(reset), .req(req),
        .din0(din0), .din1(din1), .din2(din2), .din3(din3),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .sel(sel), .grant(grant)
    );

    always #5 clk = ~clk;

    task automatic add(input logic rst, input logic [3:0] rq,
                       input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] c, input logic [15:0] d,
                       input logic rdy, input logic ev, input logic [15:0] ed,
                       input logic [1:0] es, input logic [3:0] eg);
        vec_t v;
        v.rst = rst; v.req = rq; v.d0 = a; v.d1 = b; v.d2 = c; v.d3 = d;
        v.rdy = rdy; v.ev = ev; v.ed = ed; v.es = es; v.eg = eg;
        vq.push_back(v);
    endtask

    task automatic step(input vec_t v, input string name);
        reset = v.rst; req = v.req; out_ready = v.rdy;
        din0 = v.d0; din1 = v.d1; din2 = v.d2; din3 = v.d3;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (out_valid !== v.ev || out_data !== v.ed || sel !== v.es || grant !== v.eg) begin
            errors++;
            $display("FAIL %s: got valid=%0b data=%h sel=%0d grant=%b, want valid=%0b data=%h sel=%0d grant=%b",
                     name, out_valid, out_data, sel, grant, v.ev, v.ed, v.es, v.eg);
        end
    endtask

    initial begin
        vec_t h;
        // reset then single request from source 1
        add(1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 4'b0000);
        add(1, 4'b0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 4'b0000);
        add(0, 4'b0010, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 1, 1, 16'hAAAA, 1, 4'b0000);
        add(0, 4'b0010, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 1, 0, 16'hAAAA, 1, 4'b0010);
        add(0, 4'b0010, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 1, 0, 16'hAAAA, 1, 4'b0000);
        add(0, 4'b0000, 16'h0000, 16'hAAAA, 16'h0000, 16'h0000, 1, 0, 16'hAAAA, 1, 4'b0000);
        // round-robin order 0,1,2,3 then back to 0
        add(1, 4'b0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h0000, 0, 4'b0000);
        add(0, 4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 1, 16'h1111, 0, 4'b0000);
        add(0, 4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h1111, 0, 4'b0001);
        add(0, 4'b1110, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h1111, 0, 4'b0000);
        add(0, 4'b1110, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 1, 16'h2222, 1, 4'b0000);
        add(0, 4'b1110, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h2222, 1, 4'b0010);
        add(0, 4'b1100, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h2222, 1, 4'b0000);
        add(0, 4'b1100, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 1, 16'h3333, 2, 4'b0000);
        add(0, 4'b1100, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h3333, 2, 4'b0100);
        add(0, 4'b1000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h3333, 2, 4'b0000);
        add(0, 4'b1000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 1, 16'h4444, 3, 4'b0000);
        add(0, 4'b1000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h4444, 3, 4'b1000);
        add(0, 4'b0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h4444, 3, 4'b0000);
        add(0, 4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 1, 16'h1111, 0, 4'b0000);
        add(0, 4'b1111, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h1111, 0, 4'b0001);
        add(0, 4'b0000, 16'h1111, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h1111, 0, 4'b0000);
        // backpressure: word and select frozen while inputs change
        add(0, 4'b0001, 16'h0F0F, 16'h2222, 16'h3333, 16'h4444, 0, 1, 16'h0F0F, 0, 4'b0000);
        for (int i = 0; i < 5; i++)
            add(0, 4'b1111, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 0, 1, 16'h0F0F, 0, 4'b0000);
        add(0, 4'b1111, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h0F0F, 0, 4'b0001);
        add(0, 4'b0000, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h0F0F, 0, 4'b0000);
        // fairness: after serving 3, contention 1001 goes to 0
        add(0, 4'b1000, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 0, 1, 16'h4444, 3, 4'b0000);
        add(0, 4'b1000, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h4444, 3, 4'b1000);
        add(0, 4'b1001, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 0, 0, 16'h4444, 3, 4'b0000);
        add(0, 4'b1001, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 0, 1, 16'hFFFF, 0, 4'b0000);
        // reset mid-transfer discards the word with no grant
        add(1, 4'b1001, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'h0000, 0, 4'b0000);
        add(0, 4'b1111, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 0, 1, 16'hFFFF, 0, 4'b0000);
        add(0, 4'b1111, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'hFFFF, 0, 4'b0001);
        add(0, 4'b0000, 16'hFFFF, 16'h2222, 16'h3333, 16'h4444, 1, 0, 16'hFFFF, 0, 4'b0000);
        // transfer from source 2 ahead of the idle-hold sequence
        add(0, 4'b0100, 16'hFFFF, 16'h2222, 16'h5555, 16'h4444, 0, 1, 16'h5555, 2, 4'b0000);
        add(0, 4'b0100, 16'hFFFF, 16'h2222, 16'h5555, 16'h4444, 1, 0, 16'h5555, 2, 4'b0100);
        add(0, 4'b0000, 16'hFFFF, 16'h2222, 16'h5555, 16'h4444, 1, 0, 16'h5555, 2, 4'b0000);

        reset = 1'b1; req = '0; out_ready = 1'b0;
        din0 = '0; din1 = '0; din2 = '0; din3 = '0;
        foreach (vq[i]) step(vq[i], $sformatf("vec%0d", i));

        // idle hold: nothing moves with no requests, even with out_ready high
        h = vq[vq.size() - 1];
        for (int i = 0; i < 10; i++) begin
            h.rdy = i[0];
            h.d2 = 16'h1234 + 16'(i);
            step(h, $sformatf("idle%0d", i));
        end

        // single-cycle pulse: grant must drop after exactly one cycle
        h.req = 4'b0010; h.d1 = 16'hBEEF; h.rdy = 1'b1;
        h.ev = 1'b1; h.ed = 16'hBEEF; h.es = 2'd1; h.eg = 4'b0000;
        step(h, "pulse_win");
        h.ev = 1'b0; h.eg = 4'b0010;
        step(h, "pulse_grant");
        h.req = 4'b0000; h.eg = 4'b0000;
        step(h, "pulse_drop");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/bus_arbiter4x16.md
# bus_arbiter4x16

Round-robin arbiter and transfer controller for a shared 16-bit bus built on the 4-way 16-bit mux. Four requesters each present a 16-bit word and a request. The block picks one winner fairly and drives the mux select. It snapshots the winner's word into an output register, holds it under a valid/ready handshake, and returns a one-cycle grant pulse to the winner once the consumer has taken the word. It sits between the register and memory sources and the single downstream consumer, such as a memory write port.

## Interface
- `WIDTH`, 16: data width of each source and of the output.
- `clk`  in  1  rising-edge clock, the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  4  request per source; bit k belongs to `din_k`.
- `din0`..`din3`  in  WIDTH each  source words.
- `out_ready`  in  1  consumer accepts `out_data` this cycle.
- `out_valid`  out  1  `out_data` holds a word not yet accepted.
- `out_data`  out  WIDTH  registered snapshot of the winner's word.
- `sel`  out  2  registered index of the current or last winner.
- `grant`  out  4  one-hot, one-cycle pulse to the source whose word was accepted.

## Operation
- FSM has 3 states:
  - IDLE: arbitrate.
  - BUSY: hold the word and wait for the consumer.
  - DONE: issue the grant pulse.
- IDLE:
  - If `req` is non-zero, the winner is the first set bit scanning upward from `(last+1) mod 4`.
  - Latch `sel` = winner and `out_data` = mux output at that winner.
  - Set `out_valid` = 1 and go to BUSY.
  - If `req` is zero, stay in IDLE with all outputs held.
- BUSY:
  - `out_data` and `sel` are frozen, and `req`/`din` changes are ignored.
  - On `out_valid & out_ready`: clear `out_valid`, set `last` = `sel`, set `grant` = one-hot(`sel`), go to DONE.
  - Otherwise stay in BUSY indefinitely. There is no timeout.
- DONE:
  - `grant` is high for exactly this cycle and there is no arbitration.
  - Unconditionally go to IDLE with `grant` = 0.
- Requester contract: drop `req` on the edge where it samples its `grant` bit high. The arbiter never re-grants that source off its stale request.
- A request withdrawn before it wins is simply not served. A request withdrawn after it wins has no effect, because the word is already captured.
- Fairness: any continuously asserted request is served within 4 transfers.
- Outputs after `reset`:
  - `out_valid` = 0, `out_data` = 0, `sel` = 0, `grant` = 0.
  - State = IDLE, `last` = 3, so source 0 has top priority first.
  - `reset` overrides all other activity; a pending transfer is discarded and no grant is issued.

## Timing
- Request to valid: a request sampled in IDLE at edge n gives `out_valid` = 1 and a valid `out_data`/`sel` after edge n.
- Grant timing: a handshake sampled at edge m gives the `grant` pulse during cycle m+1, and the block is back in IDLE after edge m+1.
- Minimum transfer period is 3 cycles (IDLE, BUSY with `out_ready` = 1, DONE).
- Simultaneous requests are resolved only by the rotating priority.
- `out_ready` has no effect when `out_valid` is 0.
- No combinational path exists from inputs to outputs; every output is registered.

## Structure
- Shared header (included file) holds:
  - state encodings `ST_IDLE` = 0, `ST_BUSY` = 1, `ST_DONE` = 2;
  - `N_REQ` = 4;
  - reset pointer value `LAST_RST` = 3.
- One sub-module instance of `gmux4way16`, with its select driven by the combinational round-robin winner and its output feeding the `out_data` register.
- The priority rotate/scan stays inline as a small combinational function.

## Test plan
- Reset then single request:
  - Stimulus: `reset` for 2 cycles, then `req` = 0010, `din1` = 0xAAAA, `out_ready` = 1.
  - Response: `out_valid` rises after 1 edge with `out_data` = 0xAAAA and `sel` = 1. `grant` = 0010 for one cycle, then `out_valid` = 0.
- Round-robin order:
  - Stimulus: all four requesting, `din` k = 0x1111·(k+1), each source dropping `req` on its grant.
  - Response: grant order 0, 1, 2, 3. Then, with all four re-asserted, the next winner is 0.
- Backpressure:
  - Stimulus: `req` = 0001 and `din0` = 0x0F0F with `out_ready` = 0 for 5 cycles, while `din0` changes to 0xFFFF and `req` = 1111.
  - Response: `out_data` stays 0x0F0F, `sel` stays 0, and `grant` stays 0 until `out_ready` = 1. Then `grant` = 0001.
- Fairness under contention:
  - Stimulus: `req` = 1001 held high, after a transfer to source 3.
  - Response: the next winner is source 0, not 3.
- Reset mid-transfer:
  - Stimulus: assert `reset` while in BUSY with `out_valid` = 1.
  - Response: after the edge `out_valid` = 0, `out_data` = 0x0000, `sel` = 0, and no `grant` pulse. With `req` = 1111 the next winner is 0.
- Idle hold:
  - Stimulus: `req` = 0000 for 10 cycles after a transfer from source 2 with data 0x5555.
  - Response: `out_valid` = 0, `sel` = 2, `out_data` = 0x5555, and `grant` = 0 throughout.
